// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Summary  : Multicycle MIPS-subset control FSM with bus timeout and trap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] ext_sel,
    output logic [2:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_BNE   = 6'b000101;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_ANDI  = 6'b001100;
    localparam logic [5:0] C_OP_ORI   = 6'b001101;
    localparam logic [5:0] C_OP_LUI   = 6'b001111;
    localparam logic [5:0] C_OP_J     = 6'b000010;

    localparam logic [2:0] C_ALU_AND = 3'b000;
    localparam logic [2:0] C_ALU_OR  = 3'b001;
    localparam logic [2:0] C_ALU_ADD = 3'b010;
    localparam logic [2:0] C_ALU_SUB = 3'b110;
    localparam logic [2:0] C_ALU_SLT = 3'b111;

    localparam logic [1:0] C_CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] C_CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EX     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_I_EX     = 4'd9,
        S_I_WB     = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic              r_trap;
    logic [1:0]        r_cause;
    logic [1:0]        w_cause;
    logic              w_timeout;
    logic              w_funct_ok;
    logic              w_in_wait;

    assign w_timeout  = !mem_ready && (r_wait == C_WAIT_LAST);
    assign w_in_wait  = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_funct_ok = (funct == 6'b100000) || (funct == 6'b100010) || (funct == 6'b100100) ||
                        (funct == 6'b100101) || (funct == 6'b101010);

    always_comb begin
        w_next  = r_state;
        w_cause = C_CAUSE_ILLEGAL;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next  = S_TRAP;
                    w_cause = C_CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (op)
                    C_OP_RTYPE:                           w_next = S_R_EX;
                    C_OP_LW, C_OP_SW:                     w_next = S_MEM_ADDR;
                    C_OP_BEQ, C_OP_BNE:                   w_next = S_BRANCH;
                    C_OP_ADDI, C_OP_ANDI, C_OP_ORI, C_OP_LUI: w_next = S_I_EX;
                    C_OP_J:                               w_next = S_JUMP;
                    default:                              w_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: w_next = (op == C_OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready) begin
                    w_next = S_MEM_WB;
                end else if (w_timeout) begin
                    w_next  = S_TRAP;
                    w_cause = C_CAUSE_TIMEOUT;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    w_next = S_FETCH;
                end else if (w_timeout) begin
                    w_next  = S_TRAP;
                    w_cause = C_CAUSE_TIMEOUT;
                end
            end
            S_R_EX:   w_next = w_funct_ok ? S_R_WB : S_TRAP;
            S_I_EX:   w_next = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_TRAP;
        endcase
    end

    // Wait counter restarts on every state change, so each access gets a fresh budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
            r_trap  <= 1'b0;
            r_cause <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_in_wait && !mem_ready) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
            if (w_next == S_TRAP && r_state != S_TRAP) begin
                r_trap  <= 1'b1;
                r_cause <= w_cause;
            end
        end
    end

    assign state      = r_state;
    assign trap       = r_trap;
    assign trap_cause = r_cause;

    // Decoded from state and live handshake inputs; rst masks everything at once.
    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_sel    = 2'b00;
        alu_ctrl   = 3'b000;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_re    = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctrl  = C_ALU_ADD;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_ctrl  = C_ALU_ADD;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = C_ALU_ADD;
                end
                S_MEM_RD: begin
                    iord   = 1'b1;
                    mem_re = 1'b1;
                end
                S_MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_we     = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    iord       = 1'b1;
                    mem_we     = !w_timeout;
                    instr_done = mem_ready;
                end
                S_R_EX: begin
                    alu_src_a = 1'b1;
                    case (funct)
                        6'b100000: alu_ctrl = C_ALU_ADD;
                        6'b100010: alu_ctrl = C_ALU_SUB;
                        6'b100100: alu_ctrl = C_ALU_AND;
                        6'b100101: alu_ctrl = C_ALU_OR;
                        6'b101010: alu_ctrl = C_ALU_SLT;
                        default:   alu_ctrl = 3'b000;
                    endcase
                end
                S_R_WB: begin
                    reg_dst    = 1'b1;
                    reg_we     = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_ctrl   = C_ALU_SUB;
                    pc_src     = 2'b01;
                    instr_done = 1'b1;
                    pc_we      = (op == C_OP_BNE) ? !zero : zero;
                end
                S_I_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (op)
                        C_OP_ANDI: begin ext_sel = 2'b01; alu_ctrl = C_ALU_AND; end
                        C_OP_ORI:  begin ext_sel = 2'b01; alu_ctrl = C_ALU_OR;  end
                        C_OP_LUI:  begin ext_sel = 2'b10; alu_ctrl = C_ALU_OR;  end
                        default:   begin ext_sel = 2'b00; alu_ctrl = C_ALU_ADD; end
                    endcase
                end
                S_I_WB: begin
                    reg_we     = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_src     = 2'b10;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_multicycle_ctrl
// Summary  : Directed self-checking bench for multicycle_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_we, ir_we, reg_we, mem_re, mem_we, iord, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, ext_sel, pc_src, trap_cause;
    logic [2:0] alu_ctrl;
    logic [3:0] state;
    logic       instr_done, trap;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
        .iord(iord), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_sel(ext_sel), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
        .state(state), .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    // Stimulus helpers: inputs change on the falling edge, outputs read 1ns later.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r);
        op = o; funct = f; zero = z; mem_ready = r;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set(6'd0, 6'd0, 1'b0, 1'b1);
        total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state got %0d want 0", state); end
        total++; if ({pc_we, ir_we, reg_we, mem_re, mem_we, iord, alu_src_b, alu_ctrl} !== 11'd0) begin
            bad++; $display("FAIL reset_strobes got %b want 0", {pc_we, ir_we, reg_we, mem_re, mem_we, iord, alu_src_b, alu_ctrl}); end
        total++; if ({trap, trap_cause} !== 3'b000) begin bad++; $display("FAIL reset_trap got %b want 000", {trap, trap_cause}); end
    endtask

    task automatic test_add();
        do_reset();
        set(6'b000000, 6'b100000, 1'b0, 1'b1);
        total++; if ({state, ir_we, pc_we, mem_re, iord, alu_src_b, alu_ctrl} !== {4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 3'b010}) begin
            bad++; $display("FAIL add_fetch got %b want 0000111001010", {state, ir_we, pc_we, mem_re, iord, alu_src_b, alu_ctrl}); end
        tick();
        total++; if ({state, alu_src_a, alu_src_b, alu_ctrl} !== {4'd1, 1'b0, 2'b11, 3'b010}) begin
            bad++; $display("FAIL add_decode got %b want 0001011010", {state, alu_src_a, alu_src_b, alu_ctrl}); end
        tick();
        total++; if ({state, alu_src_a, alu_src_b, alu_ctrl} !== {4'd6, 1'b1, 2'b00, 3'b010}) begin
            bad++; $display("FAIL add_rex got %b want 0110100010", {state, alu_src_a, alu_src_b, alu_ctrl}); end
        tick();
        total++; if ({state, reg_we, instr_done, reg_dst, mem_to_reg} !== {4'd7, 4'b1110}) begin
            bad++; $display("FAIL add_rwb got %b want 01111110", {state, reg_we, instr_done, reg_dst, mem_to_reg}); end
        tick();
        total++; if (state !== 4'd0) begin bad++; $display("FAIL add_next got %0d want 0", state); end
    endtask

    task automatic test_itype();
        logic [5:0] ops [4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001111};
        logic [1:0] exts[4] = '{2'b00, 2'b01, 2'b01, 2'b10};
        logic [2:0] alus[4] = '{3'b010, 3'b000, 3'b001, 3'b001};
        for (int i = 0; i < 4; i++) begin
            do_reset();
            set(ops[i], 6'd0, 1'b0, 1'b1);
            tick(); tick();
            total++; if ({state, alu_src_a, alu_src_b, ext_sel, alu_ctrl} !== {4'd9, 1'b1, 2'b10, exts[i], alus[i]}) begin
                bad++; $display("FAIL itype_ex[%0d] got %b want %b", i, {state, alu_src_a, alu_src_b, ext_sel, alu_ctrl},
                                {4'd9, 1'b1, 2'b10, exts[i], alus[i]}); end
            tick();
            total++; if ({state, reg_we, instr_done, reg_dst, mem_to_reg} !== {4'd10, 4'b1100}) begin
                bad++; $display("FAIL itype_wb[%0d] got %b want 10101100", i, {state, reg_we, instr_done, reg_dst, mem_to_reg}); end
        end
    endtask

    task automatic test_lw_wait();
        int cycles;
        do_reset();
        set(6'b100011, 6'd0, 1'b0, 1'b1);
        tick(); tick();
        total++; if ({state, alu_src_a, alu_src_b, ext_sel, alu_ctrl} !== {4'd2, 1'b1, 2'b10, 2'b00, 3'b010}) begin
            bad++; $display("FAIL lw_addr got %b want 0010110000010", {state, alu_src_a, alu_src_b, ext_sel, alu_ctrl}); end
        cycles = 3;
        for (int k = 0; k < 4; k++) begin
            tick();
            set(6'b100011, 6'd0, 1'b0, (k == 3));
            cycles++;
            total++; if ({state, mem_re, iord, reg_we} !== {4'd3, 3'b110}) begin
                bad++; $display("FAIL lw_rd[%0d] got %b want 0011110", k, {state, mem_re, iord, reg_we}); end
        end
        tick();
        cycles++;
        total++; if ({state, reg_we, mem_to_reg, reg_dst, instr_done, cycles[3:0]} !== {4'd4, 4'b1101, 4'd8}) begin
            bad++; $display("FAIL lw_wb got %b want 010011011000", {state, reg_we, mem_to_reg, reg_dst, instr_done, cycles[3:0]}); end
        tick();
        total++; if (state !== 4'd0) begin bad++; $display("FAIL lw_next got %0d want 0", state); end
    endtask

    task automatic test_branch();
        logic [5:0] ops [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
        logic       zs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       wes [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            do_reset();
            set(ops[i], 6'd0, 1'b0, 1'b1);
            tick(); tick();
            set(ops[i], 6'd0, zs[i], 1'b1);
            total++; if ({state, pc_we, pc_src, alu_ctrl, alu_src_a, instr_done} !== {4'd8, wes[i], 2'b01, 3'b110, 2'b11}) begin
                bad++; $display("FAIL branch[%0d] got %b want %b", i, {state, pc_we, pc_src, alu_ctrl, alu_src_a, instr_done},
                                {4'd8, wes[i], 2'b01, 3'b110, 2'b11}); end
        end
    endtask

    task automatic test_jump();
        do_reset();
        set(6'b000010, 6'd0, 1'b0, 1'b1);
        tick(); tick();
        total++; if ({state, pc_we, pc_src, instr_done} !== {4'd11, 1'b1, 2'b10, 1'b1}) begin
            bad++; $display("FAIL jump got %b want 10111101", {state, pc_we, pc_src, instr_done}); end
    endtask

    task automatic test_sw();
        do_reset();
        set(6'b101011, 6'd0, 1'b0, 1'b1);
        tick(); tick(); tick();
        set(6'b101011, 6'd0, 1'b0, 1'b0);
        total++; if ({state, mem_we, iord, instr_done} !== {4'd5, 3'b110}) begin
            bad++; $display("FAIL sw_wait got %b want 0101110", {state, mem_we, iord, instr_done}); end
        tick();
        set(6'b101011, 6'd0, 1'b0, 1'b1);
        total++; if ({state, mem_we, iord, instr_done} !== {4'd5, 3'b111}) begin
            bad++; $display("FAIL sw_done got %b want 0101111", {state, mem_we, iord, instr_done}); end
        tick();
        total++; if (state !== 4'd0) begin bad++; $display("FAIL sw_next got %0d want 0", state); end
    endtask

    task automatic test_illegal();
        do_reset();
        set(6'b111111, 6'd0, 1'b0, 1'b1);
        tick();
        total++; if ({state, pc_we, reg_we, mem_we} !== {4'd1, 3'b000}) begin
            bad++; $display("FAIL illegal_decode got %b want 0001000", {state, pc_we, reg_we, mem_we}); end
        tick(); tick(); tick();
        total++; if ({state, trap, trap_cause, mem_re, pc_we, ir_we} !== {4'd12, 1'b1, 2'b01, 3'b000}) begin
            bad++; $display("FAIL illegal_trap got %b want 110010 1000", {state, trap, trap_cause, mem_re, pc_we, ir_we}); end
        do_reset();
        set(6'b000000, 6'd0, 1'b0, 1'b0);
        total++; if ({state, trap, trap_cause} !== 7'd0) begin
            bad++; $display("FAIL illegal_clear got %b want 0000000", {state, trap, trap_cause}); end
        // R-type with an unsupported funct also traps as illegal.
        do_reset();
        set(6'b000000, 6'b000111, 1'b0, 1'b1);
        tick(); tick();
        total++; if ({state, reg_we} !== {4'd6, 1'b0}) begin bad++; $display("FAIL badfunct_rex got %b want 01100", {state, reg_we}); end
        tick();
        total++; if ({state, trap, trap_cause} !== {4'd12, 1'b1, 2'b01}) begin
            bad++; $display("FAIL badfunct_trap got %b want 1100101", {state, trap, trap_cause}); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            set(6'b000000, 6'b100000, 1'b0, 1'b0);
            if (k == 16) begin
                total++; if ({state, mem_re, pc_we, ir_we} !== {4'd0, 3'b100}) begin
                    bad++; $display("FAIL timeout_last got %b want 0000100", {state, mem_re, pc_we, ir_we}); end
            end
            tick();
        end
        set(6'b000000, 6'b100000, 1'b0, 1'b0);
        total++; if ({state, trap, trap_cause} !== {4'd12, 1'b1, 2'b10}) begin
            bad++; $display("FAIL timeout_trap got %b want 1100110", {state, trap, trap_cause}); end
        do_reset();
        set(6'b000000, 6'b100000, 1'b0, 1'b0);
        total++; if ({state, trap, trap_cause} !== 7'd0) begin
            bad++; $display("FAIL timeout_clear got %b want 0000000", {state, trap, trap_cause}); end
        // Ready arriving on the final allowed cycle still completes the fetch.
        for (int k = 1; k <= 16; k++) begin
            set(6'b000000, 6'b100000, 1'b0, (k == 16));
            tick();
        end
        set(6'b000000, 6'b100000, 1'b0, 1'b1);
        total++; if ({state, trap} !== {4'd1, 1'b0}) begin
            bad++; $display("FAIL timeout_edge got %b want 00010", {state, trap}); end
    endtask

    task automatic test_rst_midwr();
        do_reset();
        set(6'b101011, 6'd0, 1'b0, 1'b1);
        tick(); tick(); tick();
        set(6'b101011, 6'd0, 1'b0, 1'b0);
        total++; if ({state, mem_we} !== {4'd5, 1'b1}) begin bad++; $display("FAIL midwr_pre got %b want 01011", {state, mem_we}); end
        #2;
        rst = 1'b1;
        #1;
        total++; if ({state, mem_we, reg_we, iord} !== 7'd0) begin
            bad++; $display("FAIL midwr_rst got %b want 0000000", {state, mem_we, reg_we, iord}); end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_itype();
        test_lw_wait();
        test_branch();
        test_jump();
        test_sw();
        test_illegal();
        test_timeout();
        test_rst_midwr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
